// File: rtl/sr_async.sv
// Clocked set/reset flip-flop with a synchronous reset and a parameterised
// resolution policy for the case where set and clear are requested together.
module sr_async #(
    parameter logic RESET_VAL = 1'b0,
    parameter int   BOTH_MODE = 0
) (
    input  logic clk,
    input  logic reset,
    input  logic s,
    input  logic r,
    output logic q
);

    // Out-of-range modes fall back to hold so a bad parameter can never
    // produce an unexpected state change.
    localparam int EFF_MODE = ((BOTH_MODE < 0) || (BOTH_MODE > 3)) ? 0 : BOTH_MODE;

    logic r_q;
    logic w_next;

    always_comb begin
        w_next = r_q;
        case ({s, r})
            2'b10:   w_next = 1'b1;
            2'b01:   w_next = 1'b0;
            2'b11: begin
                case (EFF_MODE)
                    1:       w_next = 1'b1;
                    2:       w_next = 1'b0;
                    3:       w_next = ~r_q;
                    default: w_next = r_q;
                endcase
            end
            default: w_next = r_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_q <= RESET_VAL;
        end else begin
            r_q <= w_next;
        end
    end

    assign q = r_q;

endmodule

// File: tb/tb_sr_async.sv
// Directed testbench for sr_async: several instances share one stimulus
// stream so every BOTH_MODE and both reset values are exercised together.
`timescale 1ns/1ps
module tb_sr_async;

    logic clk;
    logic reset;
    logic s;
    logic r;
    logic q0;
    logic qR1;
    logic qM1;
    logic qM2;
    logic qM3;
    logic qM5;

    int checks;
    int failures;

    sr_async #(.RESET_VAL(1'b0), .BOTH_MODE(0)) dut0 (
        .clk(clk), .reset(reset), .s(s), .r(r), .q(q0));
    sr_async #(.RESET_VAL(1'b1), .BOTH_MODE(0)) dutR1 (
        .clk(clk), .reset(reset), .s(s), .r(r), .q(qR1));
    sr_async #(.RESET_VAL(1'b0), .BOTH_MODE(1)) dutM1 (
        .clk(clk), .reset(reset), .s(s), .r(r), .q(qM1));
    sr_async #(.RESET_VAL(1'b0), .BOTH_MODE(2)) dutM2 (
        .clk(clk), .reset(reset), .s(s), .r(r), .q(qM2));
    sr_async #(.RESET_VAL(1'b0), .BOTH_MODE(3)) dutM3 (
        .clk(clk), .reset(reset), .s(s), .r(r), .q(qM3));
    sr_async #(.RESET_VAL(1'b0), .BOTH_MODE(5)) dutM5 (
        .clk(clk), .reset(reset), .s(s), .r(r), .q(qM5));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive inputs, then let one rising edge pass and settle 1ns after it.
    task automatic applyStimulus(input logic iReset, input logic iS, input logic iR);
        reset = iReset;
        s     = iS;
        r     = iR;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        s     = 1'bx;
        r     = 1'bx;
        @(posedge clk);
        #1;
        checks++;
        if (q0 !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_val0: got %b expected 0", q0);
        end
        checks++;
        if (qR1 !== 1'b1) begin
            failures++;
            $display("[TB] FAIL reset_val1: got %b expected 1", qR1);
        end
        checks++;
        if ({qM1, qM2, qM3, qM5} !== 4'b0000) begin
            failures++;
            $display("[TB] FAIL reset_modes: got %b expected 0000", {qM1, qM2, qM3, qM5});
        end
        applyStimulus(1'b0, 1'b0, 1'b0);
        checks++;
        if (qR1 !== 1'b1) begin
            failures++;
            $display("[TB] FAIL reset_release_hold: got %b expected 1", qR1);
        end
    endtask

    task automatic test_set_hold_clear;
        applyStimulus(1'b0, 1'b1, 1'b0);
        checks++;
        if (q0 !== 1'b1) begin
            failures++;
            $display("[TB] FAIL set: got %b expected 1", q0);
        end
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0);
            checks++;
            if (q0 !== 1'b1) begin
                failures++;
                $display("[TB] FAIL hold_%0d: got %b expected 1", i, q0);
            end
        end
        applyStimulus(1'b0, 1'b0, 1'b1);
        checks++;
        if (q0 !== 1'b0) begin
            failures++;
            $display("[TB] FAIL clear: got %b expected 0", q0);
        end
        checks++;
        if (qR1 !== 1'b0) begin
            failures++;
            $display("[TB] FAIL clear_r1: got %b expected 0", qR1);
        end
    endtask

    task automatic test_reset_priority;
        logic [1:0] pattern [4];
        pattern[0] = 2'b01;
        pattern[1] = 2'b11;
        pattern[2] = 2'b10;
        pattern[3] = 2'b00;
        applyStimulus(1'b0, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0);
        checks++;
        if (q0 !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_over_set: got %b expected 0", q0);
        end
        checks++;
        if (qR1 !== 1'b1) begin
            failures++;
            $display("[TB] FAIL reset_over_set_r1: got %b expected 1", qR1);
        end
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, pattern[i][1], pattern[i][0]);
            checks++;
            if ({q0, qM1, qM3} !== 3'b000) begin
                failures++;
                $display("[TB] FAIL reset_hold_%0d: got %b expected 000", i, {q0, qM1, qM3});
            end
        end
        applyStimulus(1'b0, 1'b1, 1'b0);
        checks++;
        if (q0 !== 1'b1) begin
            failures++;
            $display("[TB] FAIL first_edge_after_reset: got %b expected 1", q0);
        end
    endtask

    task automatic test_reset_pulse;
        s = 1'b0;
        r = 1'b0;
        #2;
        reset = 1'b1;
        #3;
        checks++;
        if (q0 !== 1'b1) begin
            failures++;
            $display("[TB] FAIL pulse_between_edges: got %b expected 1", q0);
        end
        reset = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (q0 !== 1'b1) begin
            failures++;
            $display("[TB] FAIL pulse_after_edge: got %b expected 1", q0);
        end
    endtask

    task automatic test_both_modes;
        logic expToggle;
        applyStimulus(1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b1);
        checks++;
        if ({q0, qM1, qM2, qM3, qM5} !== 5'b01010) begin
            failures++;
            $display("[TB] FAIL both_from0: got %b expected 01010", {q0, qM1, qM2, qM3, qM5});
        end
        applyStimulus(1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b1);
        checks++;
        if ({q0, qM1, qM2, qM3, qM5} !== 5'b11001) begin
            failures++;
            $display("[TB] FAIL both_from1: got %b expected 11001", {q0, qM1, qM2, qM3, qM5});
        end
        applyStimulus(1'b1, 1'b0, 1'b0);
        expToggle = 1'b0;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b1);
            expToggle = ~expToggle;
            checks++;
            if (qM3 !== expToggle) begin
                failures++;
                $display("[TB] FAIL toggle_%0d: got %b expected %b", i, qM3, expToggle);
            end
        end
    endtask

    task automatic test_mid_period;
        applyStimulus(1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        #2;
        s = 1'b1;
        r = 1'b0;
        #6;
        checks++;
        if (q0 !== 1'b0) begin
            failures++;
            $display("[TB] FAIL mid_set_before_edge: got %b expected 0", q0);
        end
        @(posedge clk);
        #1;
        checks++;
        if (q0 !== 1'b1) begin
            failures++;
            $display("[TB] FAIL mid_set_after_edge: got %b expected 1", q0);
        end
        #3;
        s = 1'b0;
        r = 1'b1;
        #5;
        checks++;
        if (q0 !== 1'b1) begin
            failures++;
            $display("[TB] FAIL mid_clear_before_edge: got %b expected 1", q0);
        end
        @(posedge clk);
        #1;
        checks++;
        if (q0 !== 1'b0) begin
            failures++;
            $display("[TB] FAIL mid_clear_after_edge: got %b expected 0", q0);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b0;
        s        = 1'b0;
        r        = 1'b0;
        #1;
        test_reset();
        test_set_hold_clear();
        test_reset_priority();
        test_reset_pulse();
        test_both_modes();
        test_mid_period();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
